// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline controller.
// Stall vectors are {wb, mem, ex, id, if, pc}.
package pipe_ctrl_pkg;

  localparam logic [5:0] StallNone   = 6'b000000;
  localparam logic [5:0] StallFromId = 6'b000111;
  localparam logic [5:0] StallFromEx = 6'b001111;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    PcIdle    = 2'd0,
    PcDivBusy = 2'd1,
    PcDivDone = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, divider sequencing,
// flush pass-through and stall-cycle counting.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             ex_div_req_i,
  input  logic             div_ready_i,
  input  logic [63:0]      div_result_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_valid_o,
  output logic [63:0]      div_result_o,
  output logic             div_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [7:0] WaitLast = 8'(DIV_TIMEOUT - 1);

  pc_state_e  state_q;
  logic [7:0] wait_q;
  logic       rdy;
  logic       ex_stall;

  assign rdy = (div_ready_i == DivResultReady);
  assign ex_stall = (state_q == PcDivBusy) ||
                    ((state_q == PcIdle) && ex_div_req_i);

  always_comb begin
    stall_o     = StallNone;
    flush_o     = 1'b0;
    div_start_o = DivStop;
    div_annul_o = 1'b0;
    if (!rst) begin
      flush_o = flush_i;
      if (state_q == PcDivBusy) begin
        div_start_o = DivStart;
        // ready on the timeout boundary still completes
        div_annul_o = flush_i || (!rdy && (wait_q == WaitLast));
      end
      priority case (1'b1)
        flush_i:       stall_o = StallNone;
        ex_stall:      stall_o = StallFromEx;
        stallreq_id_i: stall_o = StallFromId;
        default:       stall_o = StallNone;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PcIdle;
      wait_q        <= '0;
      div_result_o  <= '0;
      div_valid_o   <= 1'b0;
      div_timeout_o <= 1'b0;
    end else begin
      div_valid_o <= 1'b0;
      case (state_q)
        PcIdle: begin
          if (!flush_i && ex_div_req_i) begin
            state_q <= PcDivBusy;
            wait_q  <= '0;
          end
        end
        PcDivBusy: begin
          if (flush_i) begin
            state_q <= PcIdle;
          end else if (rdy) begin
            div_result_o <= div_result_i;
            div_valid_o  <= 1'b1;
            state_q      <= PcDivDone;
          end else if (wait_q == WaitLast) begin
            div_timeout_o <= 1'b1;
            state_q       <= PcIdle;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        PcDivDone: state_q <= PcIdle;
        default:   state_q <= PcIdle;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (stall_o != StallNone),
    .cnt  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: instance a uses default parameters,
// instance b uses a short timeout and a 3-bit counter.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        a_sid, a_req, a_rdy, a_fl;
  logic [63:0] a_res;
  logic [5:0]  a_stall;
  logic        a_flush, a_start, a_annul, a_valid, a_tmo;
  logic [63:0] a_result;
  logic [31:0] a_cnt;

  logic        b_sid, b_req, b_rdy, b_fl;
  logic [63:0] b_res;
  logic [5:0]  b_stall;
  logic        b_flush, b_start, b_annul, b_valid, b_tmo;
  logic [63:0] b_result;
  logic [2:0]  b_cnt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] ResA = 64'h0000_0003_0000_0007;
  localparam logic [63:0] ResB = 64'hDEAD_BEEF_0000_0011;

  always #5 clk = ~clk;

  pipe_ctrl u_a (
    .clk(clk), .rst(rst),
    .stallreq_id_i(a_sid), .ex_div_req_i(a_req),
    .div_ready_i(a_rdy), .div_result_i(a_res),
    .flush_i(a_fl), .stall_o(a_stall), .flush_o(a_flush),
    .div_start_o(a_start), .div_annul_o(a_annul),
    .div_valid_o(a_valid), .div_result_o(a_result),
    .div_timeout_o(a_tmo), .stall_cnt_o(a_cnt)
  );

  pipe_ctrl #(.DIV_TIMEOUT(4), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst),
    .stallreq_id_i(b_sid), .ex_div_req_i(b_req),
    .div_ready_i(b_rdy), .div_result_i(b_res),
    .flush_i(b_fl), .stall_o(b_stall), .flush_o(b_flush),
    .div_start_o(b_start), .div_annul_o(b_annul),
    .div_valid_o(b_valid), .div_result_o(b_result),
    .div_timeout_o(b_tmo), .stall_cnt_o(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_sid = 1; a_req = 1; a_rdy = 1; a_fl = 1; a_res = '1;
    b_sid = 1; b_req = 1; b_rdy = 1; b_fl = 1; b_res = '1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", a_stall, 6'b0);
      chk("rst_flush", a_flush, 1'b0);
      chk("rst_start", a_start, 1'b0);
      chk("rst_annul", a_annul, 1'b0);
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_result", a_result, 64'h0);
      chk("rst_tmo", a_tmo, 1'b0);
      chk("rst_cnt", a_cnt, 32'h0);
      chk("rst_b_flush", b_flush, 1'b0);
      if (k == 0) tick();
    end

    rst = 1'b0;
    a_sid = 0; a_req = 0; a_rdy = 0; a_fl = 0; a_res = '0;
    b_sid = 0; b_req = 0; b_rdy = 0; b_fl = 0; b_res = '0;
    #1;
    chk("post_rst_stall", a_stall, 6'b0);
    chk("post_rst_start", a_start, 1'b0);
    chk("post_rst_cnt", a_cnt, 32'h0);
    tick();

    // ID stall for three cycles
    a_sid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("id_stall", a_stall, 6'b000111);
      tick();
    end
    a_sid = 0;
    #1;
    chk("id_stall_end", a_stall, 6'b0);
    chk("id_cnt", a_cnt, 32'd3);
    tick();

    // divide, ready on 5th busy cycle, ID stall masked
    a_req = 1; a_sid = 1;
    #1;
    chk("div_idle_stall", a_stall, 6'b001111);
    chk("div_idle_start", a_start, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      a_rdy = (i == 5);
      a_res = (i == 5) ? ResA : 64'h0;
      #1;
      chk("div_busy_stall", a_stall, 6'b001111);
      chk("div_busy_start", a_start, 1'b1);
      chk("div_busy_valid", a_valid, 1'b0);
      chk("div_busy_annul", a_annul, 1'b0);
      tick();
    end
    a_rdy = 0; a_sid = 0; a_res = '0;
    #1;
    chk("div_done_valid", a_valid, 1'b1);
    chk("div_done_result", a_result, ResA);
    chk("div_done_stall", a_stall, 6'b0);
    chk("div_done_start", a_start, 1'b0);
    chk("div_done_cnt", a_cnt, 32'd9);
    tick();
    a_req = 0;
    #1;
    chk("div_after_valid", a_valid, 1'b0);
    chk("div_after_start", a_start, 1'b0);
    chk("div_after_result", a_result, ResA);
    tick();

    // flush on 3rd busy cycle
    a_req = 1;
    #1 tick();
    #1 chk("fl_b1_annul", a_annul, 1'b0);
    tick();
    #1 chk("fl_b2_annul", a_annul, 1'b0);
    tick();
    a_fl = 1;
    #1;
    chk("fl_annul", a_annul, 1'b1);
    chk("fl_stall", a_stall, 6'b0);
    chk("fl_flush", a_flush, 1'b1);
    tick();
    a_fl = 0; a_req = 0;
    #1;
    chk("fl_idle_start", a_start, 1'b0);
    chk("fl_idle_annul", a_annul, 1'b0);
    chk("fl_idle_valid", a_valid, 1'b0);
    chk("fl_idle_flush", a_flush, 1'b0);
    chk("fl_cnt", a_cnt, 32'd12);
    tick();
    #1 chk("fl_no_valid", a_valid, 1'b0);

    // b: ready on the timeout boundary wins
    b_req = 1;
    #1 tick();
    for (int i = 1; i <= 4; i++) begin
      b_rdy = (i == 4);
      b_res = (i == 4) ? ResB : 64'h0;
      #1 chk("bnd_annul", b_annul, 1'b0);
      tick();
    end
    b_rdy = 0; b_req = 0; b_res = '0;
    #1;
    chk("bnd_valid", b_valid, 1'b1);
    chk("bnd_result", b_result, ResB);
    chk("bnd_tmo", b_tmo, 1'b0);
    chk("bnd_cnt", b_cnt, 3'd5);
    tick();
    #1 tick();

    // b: timeout abort, then retry with request held
    b_req = 1;
    #1 tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("to_start", b_start, 1'b1);
      chk("to_annul", b_annul, (i == 4));
      chk("to_tmo_pre", b_tmo, 1'b0);
      tick();
    end
    #1;
    chk("to_tmo", b_tmo, 1'b1);
    chk("to_idle_start", b_start, 1'b0);
    chk("to_idle_annul", b_annul, 1'b0);
    chk("to_idle_stall", b_stall, 6'b001111);
    chk("to_valid", b_valid, 1'b0);
    chk("to_result", b_result, ResB);
    tick();
    #1 chk("retry_start", b_start, 1'b1);
    tick();
    b_fl = 1;
    #1 chk("retry_fl_annul", b_annul, 1'b1);
    tick();
    b_fl = 0; b_req = 0; b_sid = 1;
    #1;
    chk("tmo_sticky", b_tmo, 1'b1);
    chk("sat_cnt", b_cnt, 3'd7);
    tick();
    tick();
    #1;
    chk("sat_hold", b_cnt, 3'd7);
    chk("sat_stall", b_stall, 6'b000111);
    b_sid = 0;
    chk("a_cnt_final", a_cnt, 32'd12);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
